// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states
// and STATUS register bit positions.
package irq_pkg;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_EOI     = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } irq_state_e;

  localparam int unsigned STATUS_INSVC_BIT = 31;
  localparam int unsigned STATUS_OVR_LSB   = 16;
  localparam int unsigned STATUS_OVR_W     = 15;

endpackage

// File: rtl/irq_if.sv
// Register bus and CPU interrupt handshake between the CPU side and irq_controller.
interface irq_if #(
  parameter int VEC_W = 3
);
  logic             bus_we;
  logic [1:0]       bus_addr;
  logic [31:0]      bus_wdata;
  logic [31:0]      bus_rdata;
  logic             irq;
  logic [VEC_W-1:0] irq_vec;
  logic             irq_ack;

  modport master (
    output bus_we, bus_addr, bus_wdata, irq_ack,
    input  bus_rdata, irq, irq_vec
  );

  modport slave (
    input  bus_we, bus_addr, bus_wdata, irq_ack,
    output bus_rdata, irq, irq_vec
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus a valid flag.
module irq_prio_enc #(
  parameter int NSRC  = 8,
  parameter int VEC_W = 3
) (
  input  logic [NSRC-1:0]  req,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  // Scan from the top down so the lowest set bit is the last to assign.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int unsigned i = NSRC; i > 0; i--) begin
      if (req[i-1]) begin
        idx   = VEC_W'(i - 1);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: latches source pulses, masks them, requests the CPU for the
// lowest enabled pending source. Optional sticky overrun flags under IRQ_OVERRUN_EN.
module irq_controller
  import irq_pkg::*;
#(
  parameter int NSRC  = 8,
  parameter int VEC_W = 3
) (
  input logic            clk,
  input logic            reset,
  input logic [NSRC-1:0] src_int,
  irq_if.slave           bus
);

  logic [NSRC-1:0]  pending;
  logic [NSRC-1:0]  mask;
  logic [NSRC-1:0]  eligible;
  logic [NSRC-1:0]  w1c;
  logic [NSRC-1:0]  claim_clr;
  logic [VEC_W-1:0] winner;
  logic             win_valid;
  logic             wr_pending;
  logic             wr_mask;
  logic             wr_eoi;
  logic             take_ack;
  logic             vec_live;
  logic [31:0]      rd_mux;
  irq_state_e       state;

  assign eligible   = pending & mask;
  assign wr_pending = bus.bus_we && (bus.bus_addr == REG_PENDING);
  assign wr_mask    = bus.bus_we && (bus.bus_addr == REG_MASK);
  assign wr_eoi     = bus.bus_we && (bus.bus_addr == REG_EOI);
  assign take_ack   = (state == REQ) && bus.irq_ack;
  assign vec_live   = eligible[bus.irq_vec];
  assign w1c        = wr_pending ? bus.bus_wdata[NSRC-1:0] : '0;

  always_comb begin
    claim_clr = '0;
    if (take_ack) claim_clr[bus.irq_vec] = 1'b1;
  end

  irq_prio_enc #(
    .NSRC (NSRC),
    .VEC_W(VEC_W)
  ) u_prio_enc (
    .req  (eligible),
    .idx  (winner),
    .valid(win_valid)
  );

  // A new pulse always survives a same-cycle W1C or claim clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~w1c & ~claim_clr) | src_int;
      if (wr_mask) mask <= bus.bus_wdata[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      bus.irq     <= 1'b0;
      bus.irq_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            state       <= REQ;
            bus.irq     <= 1'b1;
            bus.irq_vec <= winner;
          end
        end
        REQ: begin
          if (bus.irq_ack) begin
            state   <= INSVC;
            bus.irq <= 1'b0;
          end else if (!vec_live) begin
            state   <= IDLE;
            bus.irq <= 1'b0;
          end
        end
        INSVC: begin
          if (wr_eoi) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          bus.irq <= 1'b0;
        end
      endcase
    end
  end

`ifdef IRQ_OVERRUN_EN
  localparam int unsigned OVR_N = (NSRC < STATUS_OVR_W) ? NSRC : STATUS_OVR_W;

  logic [OVR_N-1:0] ovr;
  logic             status_rd;

  assign status_rd = (bus.bus_addr == REG_STATUS);

  // The read that returns a flag also clears it; a fresh overrun in that cycle is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr <= '0;
    end else begin
      ovr <= (status_rd ? '0 : ovr) | (src_int[OVR_N-1:0] & pending[OVR_N-1:0]);
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.bus_addr)
      REG_PENDING: rd_mux[NSRC-1:0] = pending;
      REG_MASK:    rd_mux[NSRC-1:0] = mask;
      REG_STATUS: begin
        rd_mux[STATUS_INSVC_BIT] = (state == INSVC);
        rd_mux[VEC_W-1:0]        = bus.irq_vec;
`ifdef IRQ_OVERRUN_EN
        rd_mux[STATUS_OVR_LSB +: OVR_N] = ovr;
`endif
      end
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus.bus_rdata <= '0;
    else       bus.bus_rdata <= rd_mux;
  end

endmodule
